// File: rtl/conv_result_packer_if.sv
// conv_result_packer_if
//   Result-memory write port: a single 32-bit word write with a valid/ready
//   handshake. The packer drives it through the master modport; the memory
//   (or a testbench standing in for it) uses the slave modport.
//
//   mem_valid  master->slave  write request valid
//   mem_ready  slave->master  write accepted when mem_valid && mem_ready
//   mem_addr   master->slave  {channel[1:0], word address[13:0]}
//   mem_data   master->slave  packed word, byte lane n = bits [8n+7:8n]
//   mem_be     master->slave  byte enables, one bit per lane
interface conv_result_packer_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;

  modport master (output mem_valid, output mem_addr, output mem_data,
                  output mem_be, input mem_ready);
  modport slave  (input mem_valid, input mem_addr, input mem_data,
                  input mem_be, output mem_ready);
endinterface

// File: rtl/conv_result_packer.sv
// conv_result_packer
//   Takes the three byte-wide result streams of conv_pool, packs each one
//   into 32-bit words with byte enables, buffers the words in per-channel
//   FIFOs and round-robins them onto one result-memory write port.
//
//   Parameters
//     FIFO_DEPTH  words per channel FIFO (power of two, >= 2)
//     CNT_W       width of each performance counter
//
//   Ports
//     clk, rst                   clock and synchronous active-high reset
//     in_we_k/in_addr_k/in_y_k   result byte strobe, byte address, byte (k=0..2)
//     flush                      one-cycle pulse: drain partial words and FIFOs
//     mem                        write port (conv_result_packer_if.master)
//     done                       one-cycle pulse once a flush has fully drained
//     overflow_err               sticky per channel: a word was dropped
//     words_cnt                  {ch2,ch1,ch0} accepted-write counters
//
//   Build option
//     PACKER_PERF_CNT_EN  when defined, words_cnt counts accepted writes per
//                         channel (saturating); otherwise words_cnt is 0.
module conv_result_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_we_0,
  input  logic [15:0]          in_addr_0,
  input  logic [7:0]           in_y_0,
  input  logic                 in_we_1,
  input  logic [15:0]          in_addr_1,
  input  logic [7:0]           in_y_1,
  input  logic                 in_we_2,
  input  logic [15:0]          in_addr_2,
  input  logic [7:0]           in_y_2,
  input  logic                 flush,
  conv_result_packer_if.master mem,
  output logic                 done,
  output logic [2:0]           overflow_err,
  output logic [3*CNT_W-1:0]   words_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic              w_we   [3];
  logic [15:0]       w_addr [3];
  logic [7:0]        w_y    [3];

  logic [13:0]       r_holdWaddr [3];
  logic [31:0]       r_holdData  [3];
  logic [3:0]        r_holdMask  [3];

  // FIFO entry layout: {waddr[13:0], data[31:0], mask[3:0]}
  logic [49:0]       r_fifoMem [3][FIFO_DEPTH];
  logic [PTR_W:0]    r_wrPtr   [3];
  logic [PTR_W:0]    r_rdPtr   [3];
  logic [49:0]       w_head    [3];

  logic [2:0]        w_push;
  logic [2:0]        w_pop;
  logic [2:0]        w_empty;
  logic [2:0]        w_full;
  logic [3:0]        w_avail;

  logic              r_memValid;
  logic [15:0]       r_memAddr;
  logic [31:0]       r_memData;
  logic [3:0]        r_memBe;
  logic [1:0]        r_arbPtr;
  logic              r_flushPending;
  logic              r_done;
  logic [2:0]        r_overflow;

  logic              w_load;
  logic [1:0]        w_sel;
  logic              w_selValid;
  logic [49:0]       w_selWord;

  function automatic logic [1:0] wrapCh(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign w_we   = '{in_we_0,   in_we_1,   in_we_2};
  assign w_addr = '{in_addr_0, in_addr_1, in_addr_2};
  assign w_y    = '{in_y_0,    in_y_1,    in_y_2};

  // A held word leaves for its FIFO when it is complete (lane 3 written),
  // when a byte for a different word arrives, or while a flush is draining.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_push[k]  = (r_holdMask[k] != 4'd0) &&
                   (r_holdMask[k][3] ||
                    (w_we[k] && (w_addr[k][15:2] != r_holdWaddr[k])) ||
                    r_flushPending);
      w_empty[k] = (r_wrPtr[k] == r_rdPtr[k]);
      w_full[k]  = (r_wrPtr[k][PTR_W] != r_rdPtr[k][PTR_W]) &&
                   (r_wrPtr[k][PTR_W-1:0] == r_rdPtr[k][PTR_W-1:0]);
      w_head[k]  = r_fifoMem[k][r_rdPtr[k][PTR_W-1:0]];
    end
  end

  assign w_avail = {1'b0, ~w_empty};
  assign w_load  = !r_memValid || mem.mem_ready;

  // Round-robin search from the pointer; walking offsets downward lets the
  // closest non-empty channel win.
  always_comb begin
    w_sel      = 2'd0;
    w_selValid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (w_avail[wrapCh({1'b0, r_arbPtr} + 3'(i))]) begin
        w_sel      = wrapCh({1'b0, r_arbPtr} + 3'(i));
        w_selValid = 1'b1;
      end
    end
  end

  always_comb begin
    case (w_sel)
      2'd1:    w_selWord = w_head[1];
      2'd2:    w_selWord = w_head[2];
      default: w_selWord = w_head[0];
    endcase
    for (int k = 0; k < 3; k++) begin
      w_pop[k] = w_load && w_selValid && (w_sel == 2'(k));
    end
  end

  // FIFO storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_push[k] && (!w_full[k] || w_pop[k])) begin
        r_fifoMem[k][r_wrPtr[k][PTR_W-1:0]] <=
          {r_holdWaddr[k], r_holdData[k], r_holdMask[k]};
      end
    end
  end

  // Hold registers and FIFO pointers. A push into a full FIFO is dropped and
  // flagged, unless the same FIFO is popped this cycle and so frees a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        r_holdWaddr[k] <= '0;
        r_holdData[k]  <= '0;
        r_holdMask[k]  <= '0;
        r_wrPtr[k]     <= '0;
        r_rdPtr[k]     <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_push[k]) begin
          if (!w_full[k] || w_pop[k]) begin
            r_wrPtr[k] <= r_wrPtr[k] + 1'b1;
          end else begin
            r_overflow[k] <= 1'b1;
          end
          if (w_we[k]) begin
            r_holdWaddr[k] <= w_addr[k][15:2];
            r_holdData[k]  <= 32'(w_y[k]) << {w_addr[k][1:0], 3'b000};
            r_holdMask[k]  <= 4'b0001 << w_addr[k][1:0];
          end else begin
            r_holdData[k]  <= '0;
            r_holdMask[k]  <= '0;
          end
        end else if (w_we[k]) begin
          r_holdWaddr[k] <= w_addr[k][15:2];
          r_holdData[k][{w_addr[k][1:0], 3'b000} +: 8] <= w_y[k];
          r_holdMask[k][w_addr[k][1:0]] <= 1'b1;
        end
        if (w_pop[k]) begin
          r_rdPtr[k] <= r_rdPtr[k] + 1'b1;
        end
      end
    end
  end

  // Output register: reloaded whenever the port is idle or the current word
  // is accepted, so a steady mem_ready streams words without bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memValid <= 1'b0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_memBe    <= '0;
      r_arbPtr   <= 2'd0;
    end else if (w_load) begin
      if (w_selValid) begin
        r_memValid <= 1'b1;
        r_memAddr  <= {w_sel, w_selWord[49:36]};
        r_memData  <= w_selWord[35:4];
        r_memBe    <= w_selWord[3:0];
        r_arbPtr   <= wrapCh({1'b0, w_sel} + 3'd1);
      end else begin
        r_memValid <= 1'b0;
      end
    end
  end

  // Flush bookkeeping: done fires once nothing is left anywhere in the path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flushPending <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_flushPending && (r_holdMask[0] == 4'd0) && (r_holdMask[1] == 4'd0) &&
          (r_holdMask[2] == 4'd0) && (&w_empty) && !r_memValid) begin
        r_done         <= 1'b1;
        r_flushPending <= 1'b0;
      end else if (flush) begin
        r_flushPending <= 1'b1;
      end
    end
  end

`ifdef PACKER_PERF_CNT_EN
  logic [CNT_W-1:0] r_wordsCnt [3];

  // Saturating per-channel count of accepted writes; channel comes from the
  // top bits of the address currently on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        r_wordsCnt[k] <= '0;
      end
    end else if (r_memValid && mem.mem_ready) begin
      for (int k = 0; k < 3; k++) begin
        if ((r_memAddr[15:14] == 2'(k)) && (r_wordsCnt[k] != {CNT_W{1'b1}})) begin
          r_wordsCnt[k] <= r_wordsCnt[k] + 1'b1;
        end
      end
    end
  end

  assign words_cnt = {r_wordsCnt[2], r_wordsCnt[1], r_wordsCnt[0]};
`else
  assign words_cnt = '0;
`endif

  assign mem.mem_valid = r_memValid;
  assign mem.mem_addr  = r_memAddr;
  assign mem.mem_data  = r_memData;
  assign mem.mem_be    = r_memBe;
  assign done          = r_done;
  assign overflow_err  = r_overflow;

endmodule

// File: tb/tb_conv_result_packer.sv
// tb_conv_result_packer
//   Directed bench for conv_result_packer: word packing, partial words on an
//   address change, flush/done, round-robin order, stall with FIFO overflow,
//   reset while busy, and the optional saturating write counters (CNT_W=2).
module tb_conv_result_packer;
  localparam int CNT_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_we_0, in_we_1, in_we_2;
  logic [15:0]        in_addr_0, in_addr_1, in_addr_2;
  logic [7:0]         in_y_0, in_y_1, in_y_2;
  logic               flush;
  logic               done;
  logic [2:0]         overflow_err;
  logic [3*CNT_W-1:0] words_cnt;

  int total = 0;
  int bad   = 0;

  conv_result_packer_if memIf();

  conv_result_packer #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_we_0(in_we_0), .in_addr_0(in_addr_0), .in_y_0(in_y_0),
    .in_we_1(in_we_1), .in_addr_1(in_addr_1), .in_y_1(in_y_1),
    .in_we_2(in_we_2), .in_addr_2(in_addr_2), .in_y_2(in_y_2),
    .flush(flush), .mem(memIf), .done(done),
    .overflow_err(overflow_err), .words_cnt(words_cnt)
  );

  always #5 clk = ~clk;

  // Expected counter vector; saturates at 3 for CNT_W=2, zero without the option.
  function automatic logic [3*CNT_W-1:0] expCnt(input int c2, input int c1, input int c0);
`ifdef PACKER_PERF_CNT_EN
    return {2'((c2 > 3) ? 3 : c2), 2'((c1 > 3) ? 3 : c1), 2'((c0 > 3) ? 3 : c0)};
`else
    return '0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMem(input string tag, input logic [15:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
    checkOutput({tag, "_valid"}, 32'(memIf.mem_valid), 32'd1);
    checkOutput({tag, "_addr"},  32'(memIf.mem_addr),  32'(addr));
    checkOutput({tag, "_data"},  memIf.mem_data,       data);
    checkOutput({tag, "_be"},    32'(memIf.mem_be),    32'(be));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    in_we_0 = 1'b0; in_addr_0 = '0; in_y_0 = '0;
    in_we_1 = 1'b0; in_addr_1 = '0; in_y_1 = '0;
    in_we_2 = 1'b0; in_addr_2 = '0; in_y_2 = '0;
    flush   = 1'b0;
  endtask

  task automatic applyStimulus(input int ch, input logic [15:0] addr, input logic [7:0] y);
    case (ch)
      0:       begin in_we_0 = 1'b1; in_addr_0 = addr; in_y_0 = y; end
      1:       begin in_we_1 = 1'b1; in_addr_1 = addr; in_y_1 = y; end
      default: begin in_we_2 = 1'b1; in_addr_2 = addr; in_y_2 = y; end
    endcase
  endtask

  initial begin
    clearInputs();
    memIf.mem_ready = 1'b0;
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("rst_valid", 32'(memIf.mem_valid), 32'd0);
    checkOutput("rst_addr",  32'(memIf.mem_addr),  32'd0);
    checkOutput("rst_data",  memIf.mem_data,       32'd0);
    checkOutput("rst_be",    32'(memIf.mem_be),    32'd0);
    checkOutput("rst_done",  32'(done),            32'd0);
    checkOutput("rst_ovf",   32'(overflow_err),    32'd0);
    checkOutput("rst_cnt",   32'(words_cnt),       32'd0);
    rst = 1'b0;

    // Full ch0 word, issued two edges after the lane-3 byte
    memIf.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clearInputs();
      applyStimulus(0, 16'(i), 8'(8'h11 * (i + 1)));
      stepCycle();
    end
    clearInputs();
    stepCycle();
    checkOutput("w0_early", 32'(memIf.mem_valid), 32'd0);
    stepCycle();
    checkMem("w0", 16'h0000, 32'h44332211, 4'hF);
    stepCycle();
    checkOutput("w0_gone", 32'(memIf.mem_valid), 32'd0);

    // Partial ch1 word pushed by an address change, second byte by flush
    applyStimulus(1, 16'h0005, 8'hAA);
    stepCycle();
    clearInputs();
    applyStimulus(1, 16'h0008, 8'hBB);
    stepCycle();
    clearInputs();
    stepCycle();
    checkMem("p1", 16'h4001, 32'h0000AA00, 4'h2);
    stepCycle();
    checkOutput("p1_gone", 32'(memIf.mem_valid), 32'd0);
    flush = 1'b1;
    stepCycle();
    clearInputs();
    stepCycle();
    stepCycle();
    checkMem("p2", 16'h4002, 32'h000000BB, 4'h1);
    checkOutput("p2_done_lo", 32'(done), 32'd0);
    stepCycle();
    checkOutput("p2_gone", 32'(memIf.mem_valid), 32'd0);
    checkOutput("p2_done_wait", 32'(done), 32'd0);
    stepCycle();
    checkOutput("p2_done", 32'(done), 32'd1);
    stepCycle();
    checkOutput("p2_done_pulse", 32'(done), 32'd0);
    checkOutput("cnt_a", 32'(words_cnt), 32'(expCnt(0, 2, 1)));

    // Reset brings the arbiter pointer back to ch0
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("cnt_rst", 32'(words_cnt), 32'd0);

    // Two rounds of simultaneous full words on all channels
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        clearInputs();
        applyStimulus(0, 16'(16'h0010 + 16'(r * 'h40) + 16'(i)), 8'(8'h01 + r * 'h40 + i));
        applyStimulus(1, 16'(16'h0020 + 16'(r * 'h40) + 16'(i)), 8'(8'h11 + r * 'h40 + i));
        applyStimulus(2, 16'(16'h0030 + 16'(r * 'h40) + 16'(i)), 8'(8'h21 + r * 'h40 + i));
        stepCycle();
      end
      clearInputs();
      stepCycle();
      stepCycle();
      if (r == 0) begin
        checkMem("rr0_ch0", 16'h0004, 32'h04030201, 4'hF);
        stepCycle();
        checkMem("rr0_ch1", 16'h4008, 32'h14131211, 4'hF);
        stepCycle();
        checkMem("rr0_ch2", 16'h800C, 32'h24232221, 4'hF);
      end else begin
        checkMem("rr1_ch0", 16'h0014, 32'h44434241, 4'hF);
        stepCycle();
        checkMem("rr1_ch1", 16'h4018, 32'h54535251, 4'hF);
        stepCycle();
        checkMem("rr1_ch2", 16'h801C, 32'h64636261, 4'hF);
      end
      stepCycle();
      checkOutput("rr_gone", 32'(memIf.mem_valid), 32'd0);
    end

    // Stall while ch2 streams six words: one held on the port, four queued,
    // the sixth dropped
    memIf.mem_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      clearInputs();
      applyStimulus(2, 16'(i), 8'(i + 1));
      stepCycle();
      if (i == 5) checkMem("stall_first", 16'h8000, 32'h04030201, 4'hF);
    end
    clearInputs();
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("stall_ovf", 32'(overflow_err), 32'h4);
    checkMem("stall_hold", 16'h8000, 32'h04030201, 4'hF);
    memIf.mem_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      checkMem($sformatf("drain%0d", w), 16'(16'h8000 | 16'(w)),
               {8'(4 * w + 4), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1)}, 4'hF);
      stepCycle();
    end
    checkOutput("drain_end", 32'(memIf.mem_valid), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow_err), 32'h4);
    checkOutput("cnt_b", 32'(words_cnt), 32'(expCnt(7, 2, 2)));

    // Reset while a word is on the port and another is queued
    memIf.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clearInputs();
      applyStimulus(0, 16'(16'h0080 + 16'(i)), 8'(8'hC0 + i));
      stepCycle();
    end
    clearInputs();
    stepCycle();
    stepCycle();
    checkOutput("busy_valid", 32'(memIf.mem_valid), 32'd1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(memIf.mem_valid), 32'd0);
    checkOutput("mid_rst_addr",  32'(memIf.mem_addr),  32'd0);
    checkOutput("mid_rst_data",  memIf.mem_data,       32'd0);
    checkOutput("mid_rst_be",    32'(memIf.mem_be),    32'd0);
    checkOutput("mid_rst_ovf",   32'(overflow_err),    32'd0);
    checkOutput("mid_rst_cnt",   32'(words_cnt),       32'd0);
    memIf.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput($sformatf("quiet_valid%0d", i), 32'(memIf.mem_valid), 32'd0);
      checkOutput($sformatf("quiet_done%0d", i),  32'(done),            32'd0);
    end

    // Five full ch0 words drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      clearInputs();
      applyStimulus(0, 16'(16'h0100 + 16'(i)), 8'(i));
      stepCycle();
    end
    clearInputs();
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("sat_idle", 32'(memIf.mem_valid), 32'd0);
    checkOutput("sat_cnt", 32'(words_cnt), 32'(expCnt(0, 0, 5)));

    // Flush with nothing buffered completes on the following edge
    flush = 1'b1;
    stepCycle();
    clearInputs();
    checkOutput("idle_flush_lo", 32'(done), 32'd0);
    stepCycle();
    checkOutput("idle_flush_done", 32'(done), 32'd1);
    stepCycle();
    checkOutput("idle_flush_pulse", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
